// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU types: machine word and opcode widths, the memory opcodes the
// MEM stage decodes (LW/SW/LL/SC), the memory-control encodings carried on
// Mem_i, and the MEM-stage controller state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    // Word-granular address used by the LL/SC link (byte offset dropped)
    typedef logic [29:0] word_addr_t;

    localparam opcode_t LW = 6'b100011;
    localparam opcode_t SW = 6'b101011;
    localparam opcode_t LL = 6'b110000;
    localparam opcode_t SC = 6'b111000;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        HOLD,
        FLUSH,
        HALTED
    } mem_state_t;

    // Strip the byte offset so link and snoop addresses compare per word
    function automatic word_addr_t word_addr(input word_t byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/mem_stage_link_reg.sv
// link_reg
// LL/SC link register: one valid bit plus the linked word address.
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   ll_set        an LL completed this cycle; link to req_addr
//   store_hit     an SW/SC write completed this cycle at req_addr
//   req_addr      word address of the instruction in the MEM stage
//   snoop_valid   coherence invalidate is present this cycle
//   snoop_addr    word address being invalidated
//   link_hit      link is valid and matches req_addr (SC may proceed)
//   snoop_kill    this cycle's snoop hits the live link
module link_reg
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       ll_set,
    input  logic       store_hit,
    input  word_addr_t req_addr,
    input  logic       snoop_valid,
    input  word_addr_t snoop_addr,
    output logic       link_hit,
    output logic       snoop_kill
);

    logic       link_valid;
    word_addr_t link_addr;

    assign link_hit   = link_valid && (link_addr == req_addr);
    assign snoop_kill = snoop_valid && link_valid && (snoop_addr == link_addr);

    // A new LL takes priority over any clear in the same cycle, so an LL that
    // races a matching snoop still leaves a live link. A completed store only
    // breaks the link when it lands on the linked word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (ll_set) begin
            link_valid <= 1'b1;
            link_addr  <= req_addr;
        end else if (snoop_kill || (store_hit && link_hit)) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage controller between EX/MEM and MEM/WB. Issues one dcache
// request per load/store, stalls the upstream pipeline until the cache hits,
// holds the result until MEM/WB captures it, tracks the LL/SC link and runs
// the halt-time dcache flush.
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   advance_i         MEM/WB captures at this edge
//   opcode_i, Mem_i   instruction opcode and memory control from EX/MEM
//   alu_out_i, rt_i   byte address and store data
//   halt_i            halt instruction present in the stage
//   dhit_i            dcache completed the request (dmemload_i valid)
//   ccinv_i           coherence invalidate snoop at ccsnoopaddr_i
//   dflushed_i        dcache flush complete
//   dREN_o, dWEN_o    dcache read/write request
//   daddr_o, dstore_o request address and write data
//   dflush_o          flush request
//   dload_o           load data or SC status toward MEM/WB
//   mem_stall_o       freeze PC, IF/ID, ID/EX and EX/MEM
//   halted_o          flush done, core halted
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       advance_i,
    input  opcode_t    opcode_i,
    input  logic [1:0] Mem_i,
    input  word_t      alu_out_i,
    input  word_t      rt_i,
    input  logic       halt_i,
    input  logic       dhit_i,
    input  word_t      dmemload_i,
    input  logic       ccinv_i,
    input  word_t      ccsnoopaddr_i,
    input  logic       dflushed_i,
    output logic       dREN_o,
    output logic       dWEN_o,
    output word_t      daddr_o,
    output word_t      dstore_o,
    output logic       dflush_o,
    output word_t      dload_o,
    output logic       mem_stall_o,
    output logic       halted_o
);

    mem_state_t state, next_state;

    word_t dload_q;
    word_t dload_next;
    logic  dload_en;

    logic is_read;
    logic is_write;
    logic mem_op_valid;
    logic is_ll;
    logic is_sc;
    logic is_sw;
    logic access_hit;
    logic ll_set;
    logic store_hit;
    logic link_hit;
    logic snoop_kill;
    logic unused_snoop_offset;

    assign is_read      = (Mem_i == MEM_READ);
    assign is_write     = (Mem_i == MEM_WRITE);
    assign mem_op_valid = is_read || is_write;
    assign is_ll        = (opcode_i == LL);
    assign is_sc        = (opcode_i == SC);
    assign is_sw        = (opcode_i == SW);

    assign access_hit = (state == ACCESS) && dhit_i;
    assign ll_set     = access_hit && is_read && is_ll;
    assign store_hit  = access_hit && is_write && (is_sw || is_sc);

    // EX/MEM is frozen while stalled, so these pass straight through stably
    assign daddr_o  = alu_out_i;
    assign dstore_o = rt_i;
    assign dload_o  = dload_q;

    // Snoops are word-granular; the byte offset never matters
    assign unused_snoop_offset = ^ccsnoopaddr_i[1:0];

    link_reg u_link_reg (
        .CLK         (CLK),
        .RST         (RST),
        .ll_set      (ll_set),
        .store_hit   (store_hit),
        .req_addr    (word_addr(alu_out_i)),
        .snoop_valid (ccinv_i),
        .snoop_addr  (word_addr(ccsnoopaddr_i)),
        .link_hit    (link_hit),
        .snoop_kill  (snoop_kill)
    );

    // State and result registers. dload only changes on a capture so the
    // value stays stable in HOLD until MEM/WB takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            dload_q <= '0;
        end else begin
            state <= next_state;
            if (dload_en) begin
                dload_q <= dload_next;
            end
        end
    end

    // Next-state and Moore request outputs. A failing SC is resolved from
    // IDLE without ever touching the cache. An SC whose link is killed by a
    // snoop while waiting on the cache bails out to HOLD immediately so the
    // write request is gone the following cycle; a hit in the same cycle
    // means the cache already took the write, so the hit wins.
    always_comb begin
        next_state  = state;
        dload_en    = 1'b0;
        dload_next  = dload_q;
        dREN_o      = 1'b0;
        dWEN_o      = 1'b0;
        dflush_o    = 1'b0;
        mem_stall_o = 1'b0;
        halted_o    = 1'b0;

        case (state)
            IDLE: begin
                if (halt_i) begin
                    mem_stall_o = 1'b1;
                    next_state  = FLUSH;
                end else if (mem_op_valid) begin
                    mem_stall_o = 1'b1;
                    if (is_sc && !link_hit) begin
                        next_state = HOLD;
                        dload_en   = 1'b1;
                        dload_next = '0;
                    end else begin
                        next_state = ACCESS;
                    end
                end
            end

            ACCESS: begin
                mem_stall_o = 1'b1;
                dREN_o      = is_read;
                dWEN_o      = is_write;
                if (dhit_i) begin
                    next_state = HOLD;
                    if (is_read) begin
                        dload_en   = 1'b1;
                        dload_next = dmemload_i;
                    end else if (is_sc) begin
                        dload_en   = 1'b1;
                        dload_next = 32'd1;
                    end
                end else if (is_sc && (!link_hit || snoop_kill)) begin
                    next_state = HOLD;
                    dload_en   = 1'b1;
                    dload_next = '0;
                end
            end

            HOLD: begin
                if (advance_i) begin
                    next_state = IDLE;
                end
            end

            FLUSH: begin
                mem_stall_o = 1'b1;
                dflush_o    = 1'b1;
                if (dflushed_i) begin
                    next_state = HALTED;
                end
            end

            HALTED: begin
                mem_stall_o = 1'b1;
                halted_o    = 1'b1;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Self-checking bench for mem_stage. Expected results are queued when an
// operation is launched and popped when the stage reaches HOLD.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic       advance_i;
    opcode_t    opcode_i;
    logic [1:0] Mem_i;
    word_t      alu_out_i;
    word_t      rt_i;
    logic       halt_i;
    logic       dhit_i;
    word_t      dmemload_i;
    logic       ccinv_i;
    word_t      ccsnoopaddr_i;
    logic       dflushed_i;
    logic       dREN_o;
    logic       dWEN_o;
    word_t      daddr_o;
    word_t      dstore_o;
    logic       dflush_o;
    word_t      dload_o;
    logic       mem_stall_o;
    logic       halted_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    word_t sb_q[$];
    word_t exp_dload;

    int    obs_ren;
    int    obs_wen;
    int    obs_stall;
    bit    obs_stable;
    bit    obs_done;
    word_t obs_dload;

    always #5 CLK = ~CLK;

    mem_stage dut (
        .CLK           (CLK),
        .RST           (RST),
        .advance_i     (advance_i),
        .opcode_i      (opcode_i),
        .Mem_i         (Mem_i),
        .alu_out_i     (alu_out_i),
        .rt_i          (rt_i),
        .halt_i        (halt_i),
        .dhit_i        (dhit_i),
        .dmemload_i    (dmemload_i),
        .ccinv_i       (ccinv_i),
        .ccsnoopaddr_i (ccsnoopaddr_i),
        .dflushed_i    (dflushed_i),
        .dREN_o        (dREN_o),
        .dWEN_o        (dWEN_o),
        .daddr_o       (daddr_o),
        .dstore_o      (dstore_o),
        .dflush_o      (dflush_o),
        .dload_o       (dload_o),
        .mem_stall_o   (mem_stall_o),
        .halted_o      (halted_o)
    );

    // Drives one memory op from IDLE to HOLD, playing the dcache: dhit on the
    // hit_at-th request cycle, optional snoop on the snoop_at-th. Records
    // request/stall cycle counts and the value presented in HOLD.
    task automatic applyStimulus(input opcode_t op, input logic [1:0] mem,
                                 input word_t addr, input word_t data,
                                 input int hit_at, input word_t load_data,
                                 input int snoop_at, input word_t snoop_addr);
        int acc;
        acc        = 0;
        obs_ren    = 0;
        obs_wen    = 0;
        obs_stall  = 0;
        obs_stable = 1'b1;
        obs_done   = 1'b0;
        obs_dload  = '0;
        @(negedge CLK);
        opcode_i  = op;
        Mem_i     = mem;
        alu_out_i = addr;
        rt_i      = data;
        for (int cyc = 0; cyc < 40 && !obs_done; cyc++) begin
            if (cyc != 0) @(negedge CLK);
            dhit_i  = 1'b0;
            ccinv_i = 1'b0;
            #1;
            if (dREN_o) obs_ren++;
            if (dWEN_o) obs_wen++;
            if (mem_stall_o) obs_stall++;
            if (daddr_o !== addr || dstore_o !== data) obs_stable = 1'b0;
            if (!mem_stall_o) begin
                obs_done  = 1'b1;
                obs_dload = dload_o;
                advance_i = 1'b1;
            end else if (dREN_o || dWEN_o) begin
                if (acc == hit_at) begin
                    dhit_i     = 1'b1;
                    dmemload_i = load_data;
                end
                if (acc == snoop_at) begin
                    ccinv_i       = 1'b1;
                    ccsnoopaddr_i = snoop_addr;
                end
                acc++;
            end
        end
        @(negedge CLK);
        advance_i  = 1'b0;
        dhit_i     = 1'b0;
        ccinv_i    = 1'b0;
        opcode_i   = '0;
        Mem_i      = 2'b00;
        alu_out_i  = '0;
        rt_i       = '0;
        dmemload_i = '0;
    endtask

    // One idle-cycle coherence invalidate
    task automatic applySnoop(input word_t addr);
        @(negedge CLK);
        ccinv_i       = 1'b1;
        ccsnoopaddr_i = addr;
        @(negedge CLK);
        ccinv_i       = 1'b0;
        ccsnoopaddr_i = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        n_compared++;
        if (dREN_o !== 1'b0 || dWEN_o !== 1'b0 || dflush_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_requests: got ren=%b wen=%b flush=%b expected 0/0/0", dREN_o, dWEN_o, dflush_o);
        end
        n_compared++;
        if (halted_o !== 1'b0 || mem_stall_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_status: got halted=%b stall=%b expected 0/0", halted_o, mem_stall_o);
        end
        n_compared++;
        if (dload_o !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_dload: got %h expected 00000000", dload_o);
        end
        RST = 1'b0;
    endtask

    task automatic test_load();
        sb_q.push_back(32'hDEADBEEF);
        applyStimulus(LW, MEM_READ, 32'h100, 32'h0, 0, 32'hDEADBEEF, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_done !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL load_timeout: got done=%b expected 1", obs_done);
        end
        n_compared++;
        if (obs_ren !== 1 || obs_wen !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL load_requests: got ren=%0d wen=%0d expected 1/0", obs_ren, obs_wen);
        end
        n_compared++;
        if (obs_stall !== 2) begin
            n_mismatched++;
            $display("[TB] FAIL load_stall: got %0d expected 2", obs_stall);
        end
        n_compared++;
        if (obs_dload !== exp_dload) begin
            n_mismatched++;
            $display("[TB] FAIL load_data: got %h expected %h", obs_dload, exp_dload);
        end
    endtask

    task automatic test_store_miss();
        // A plain store leaves the previous result untouched
        sb_q.push_back(32'hDEADBEEF);
        applyStimulus(SW, MEM_WRITE, 32'h200, 32'h12345678, 5, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_wen !== 6 || obs_ren !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL store_requests: got wen=%0d ren=%0d expected 6/0", obs_wen, obs_ren);
        end
        n_compared++;
        if (obs_stall !== 7) begin
            n_mismatched++;
            $display("[TB] FAIL store_stall: got %0d expected 7", obs_stall);
        end
        n_compared++;
        if (obs_stable !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL store_addr_data_stable: got %b expected 1", obs_stable);
        end
        n_compared++;
        if (obs_done !== 1'b1 || obs_dload !== exp_dload) begin
            n_mismatched++;
            $display("[TB] FAIL store_dload: got done=%b %h expected 1 %h", obs_done, obs_dload, exp_dload);
        end
    endtask

    task automatic test_dhit_ignored();
        @(negedge CLK);
        dhit_i     = 1'b1;
        dmemload_i = 32'h55555555;
        @(negedge CLK);
        dhit_i     = 1'b0;
        dmemload_i = '0;
        #1;
        n_compared++;
        if (dload_o !== 32'hDEADBEEF || mem_stall_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_dhit: got dload=%h stall=%b expected deadbeef 0", dload_o, mem_stall_o);
        end
    endtask

    task automatic test_ll_sc();
        sb_q.push_back(32'hCAFEF00D);
        applyStimulus(LL, MEM_READ, 32'h300, 32'h0, 1, 32'hCAFEF00D, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_ren !== 2) begin
            n_mismatched++;
            $display("[TB] FAIL ll_load: got %h ren=%0d expected %h ren=2", obs_dload, obs_ren, exp_dload);
        end
        sb_q.push_back(32'd1);
        applyStimulus(SC, MEM_WRITE, 32'h300, 32'hAAAA5555, 0, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_wen !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL sc_success: got %h wen=%0d expected %h wen=1", obs_dload, obs_wen, exp_dload);
        end
        sb_q.push_back(32'd0);
        applyStimulus(SC, MEM_WRITE, 32'h300, 32'hAAAA5555, 0, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_wen !== 0 || obs_stall !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL sc_second: got %h wen=%0d stall=%0d expected %h wen=0 stall=1", obs_dload, obs_wen, obs_stall, exp_dload);
        end
    endtask

    task automatic test_snoop();
        sb_q.push_back(32'h11112222);
        applyStimulus(LL, MEM_READ, 32'h300, 32'h0, 0, 32'h11112222, -1, 32'h0);
        void'(sb_q.pop_front());
        applySnoop(32'h304);
        sb_q.push_back(32'd1);
        applyStimulus(SC, MEM_WRITE, 32'h300, 32'h1, 0, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_wen !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL snoop_other_word: got %h wen=%0d expected %h wen=1", obs_dload, obs_wen, exp_dload);
        end
        sb_q.push_back(32'h33334444);
        applyStimulus(LL, MEM_READ, 32'h300, 32'h0, 0, 32'h33334444, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload) begin
            n_mismatched++;
            $display("[TB] FAIL snoop_relink: got %h expected %h", obs_dload, exp_dload);
        end
        applySnoop(32'h304);
        applySnoop(32'h300);
        sb_q.push_back(32'd0);
        applyStimulus(SC, MEM_WRITE, 32'h300, 32'h1, 0, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_wen !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL snoop_kill_link: got %h wen=%0d expected %h wen=0", obs_dload, obs_wen, exp_dload);
        end
    endtask

    task automatic test_store_clears_link();
        sb_q.push_back(32'h77778888);
        applyStimulus(LL, MEM_READ, 32'h300, 32'h0, 0, 32'h77778888, -1, 32'h0);
        void'(sb_q.pop_front());
        sb_q.push_back(32'h77778888);
        applyStimulus(SW, MEM_WRITE, 32'h300, 32'h9, 0, 32'h0, -1, 32'h0);
        void'(sb_q.pop_front());
        sb_q.push_back(32'd0);
        applyStimulus(SC, MEM_WRITE, 32'h300, 32'h1, 0, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_wen !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL sw_clears_link: got %h wen=%0d expected %h wen=0", obs_dload, obs_wen, exp_dload);
        end
    endtask

    task automatic test_sc_abort();
        sb_q.push_back(32'hABCD0123);
        applyStimulus(LL, MEM_READ, 32'h300, 32'h0, 0, 32'hABCD0123, -1, 32'h0);
        void'(sb_q.pop_front());
        // Cache never hits before the snoop lands on the third write cycle
        sb_q.push_back(32'd0);
        applyStimulus(SC, MEM_WRITE, 32'h300, 32'h5, 20, 32'h0, 2, 32'h300);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_wen !== 3) begin
            n_mismatched++;
            $display("[TB] FAIL sc_abort_wen: got %0d expected 3", obs_wen);
        end
        n_compared++;
        if (obs_done !== 1'b1 || obs_dload !== exp_dload) begin
            n_mismatched++;
            $display("[TB] FAIL sc_abort_dload: got done=%b %h expected 1 %h", obs_done, obs_dload, exp_dload);
        end
    endtask

    task automatic test_reset_mid_access();
        sb_q.push_back(32'h0BADF00D);
        applyStimulus(LL, MEM_READ, 32'h500, 32'h0, 0, 32'h0BADF00D, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload) begin
            n_mismatched++;
            $display("[TB] FAIL pre_reset_load: got %h expected %h", obs_dload, exp_dload);
        end
        @(negedge CLK);
        opcode_i  = LW;
        Mem_i     = MEM_READ;
        alu_out_i = 32'h400;
        repeat (3) @(negedge CLK);
        #1;
        n_compared++;
        if (dREN_o !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL miss_ren_held: got %b expected 1", dREN_o);
        end
        RST       = 1'b1;
        opcode_i  = '0;
        Mem_i     = 2'b00;
        alu_out_i = '0;
        @(negedge CLK);
        #1;
        n_compared++;
        if (dREN_o !== 1'b0 || mem_stall_o !== 1'b0 || dload_o !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_access: got ren=%b stall=%b dload=%h expected 0 0 00000000", dREN_o, mem_stall_o, dload_o);
        end
        RST = 1'b0;
        // The link set by the LL above must not survive reset
        sb_q.push_back(32'd0);
        applyStimulus(SC, MEM_WRITE, 32'h500, 32'h1, 0, 32'h0, -1, 32'h0);
        exp_dload = sb_q.pop_front();
        n_compared++;
        if (obs_dload !== exp_dload || obs_wen !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_clears_link: got %h wen=%0d expected %h wen=0", obs_dload, obs_wen, exp_dload);
        end
    endtask

    task automatic test_halt();
        int  flush_cyc;
        bit  got_halt;
        int  halted_cyc;
        flush_cyc = 0;
        got_halt  = 1'b0;
        @(negedge CLK);
        halt_i = 1'b1;
        for (int cyc = 0; cyc < 40 && !got_halt; cyc++) begin
            if (cyc != 0) @(negedge CLK);
            dflushed_i = 1'b0;
            #1;
            if (halted_o) begin
                got_halt = 1'b1;
            end else if (dflush_o) begin
                flush_cyc++;
                if (flush_cyc == 10) dflushed_i = 1'b1;
            end
        end
        n_compared++;
        if (got_halt !== 1'b1 || flush_cyc !== 10) begin
            n_mismatched++;
            $display("[TB] FAIL halt_flush: got halted=%b flush_cycles=%0d expected 1 10", got_halt, flush_cyc);
        end
        n_compared++;
        if (dflush_o !== 1'b0 || mem_stall_o !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL halted_outputs: got flush=%b stall=%b expected 0 1", dflush_o, mem_stall_o);
        end
        halt_i     = 1'b0;
        halted_cyc = 0;
        repeat (5) begin
            @(negedge CLK);
            #1;
            if (halted_o && mem_stall_o) halted_cyc++;
        end
        n_compared++;
        if (halted_cyc !== 5) begin
            n_mismatched++;
            $display("[TB] FAIL halted_sticky: got %0d cycles expected 5", halted_cyc);
        end
        RST = 1'b1;
        @(negedge CLK);
        #1;
        n_compared++;
        if (halted_o !== 1'b0 || mem_stall_o !== 1'b0 || dflush_o !== 1'b0 || dload_o !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL halt_reset: got halted=%b stall=%b flush=%b dload=%h expected 0 0 0 00000000", halted_o, mem_stall_o, dflush_o, dload_o);
        end
        RST = 1'b0;
    endtask

    // Global time bound so a stuck DUT still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST           = 1'b1;
        advance_i     = 1'b0;
        opcode_i      = '0;
        Mem_i         = 2'b00;
        alu_out_i     = '0;
        rt_i          = '0;
        halt_i        = 1'b0;
        dhit_i        = 1'b0;
        dmemload_i    = '0;
        ccinv_i       = 1'b0;
        ccsnoopaddr_i = '0;
        dflushed_i    = 1'b0;
        $display("[TB] mem_stage bench start");
        test_reset();
        test_load();
        test_store_miss();
        test_dhit_ignored();
        test_ll_sc();
        test_snoop();
        test_store_clears_link();
        test_sc_abort();
        test_reset_mid_access();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage controller between the EX/MEM and MEM/WB pipeline latches of each core. It:
- sequences one dcache read or write per load/store instruction and stalls the pipeline until the cache hits;
- holds the loaded word stable until the MEM/WB latch accepts it;
- maintains the LL/SC link register, including snoop invalidation;
- runs the halt-time cache flush handshake.

## Interface
Parameters: none. All widths come from `cpu_types_pkg`: `word_t` is 32 bits, `opcode_t` is 6 bits.

- CLK  in  1  pipeline clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- advance_i  in  1  MEM/WB latch enable; high means the latch captures at this edge
- opcode_i  in  opcode_t  instruction opcode from EX/MEM
- Mem_i  in  2  memory control: 2'b01 read, 2'b10 write, 2'b00 or 2'b11 none
- alu_out_i  in  word_t  effective byte address
- rt_i  in  word_t  store data
- halt_i  in  1  halt instruction is present in the stage
- dhit_i  in  1  dcache completed the current request this cycle
- dmemload_i  in  word_t  read data; valid when dhit_i is high
- ccinv_i  in  1  coherence invalidate snoop is valid
- ccsnoopaddr_i  in  word_t  snoop byte address
- dflushed_i  in  1  dcache flush is complete
- dREN_o  out  1  dcache read request
- dWEN_o  out  1  dcache write request
- daddr_o  out  word_t  request address, equal to alu_out_i
- dstore_o  out  word_t  write data, equal to rt_i
- dflush_o  out  1  flush request to dcache
- dload_o  out  word_t  result to MEM/WB: load data, or SC status (1 = success, 0 = fail)
- mem_stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- halted_o  out  1  flush complete; core is halted

## Operation
- State machine (`mem_state_t`):
  - IDLE:
    - RST wins over any transition below.
    - halt_i → FLUSH.
    - SC with link invalid, or link address ≠ alu_out_i[31:2] → HOLD, with dload = 0. No write is issued.
    - Any other op with Mem_i ∈ {01, 10} → ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - dREN_o = (Mem_i == 01); dWEN_o = (Mem_i == 10).
    - On dhit_i → HOLD. A read captures dmemload_i into dload; an SC captures 1.
  - HOLD: no request is driven. If advance_i → IDLE; otherwise stay in HOLD.
  - FLUSH: dflush_o = 1. On dflushed_i → HALTED.
  - HALTED: halted_o = 1. Stays here until RST.
- mem_stall_o is high in all of these cases:
  - IDLE with a valid mem op or halt_i;
  - ACCESS;
  - FLUSH;
  - HALTED.
- mem_stall_o is low in HOLD and in IDLE with no op.
- dload_o is a register, updated only on the captures listed above. In IDLE with no mem op, it is still what the MEM/WB latch samples; the writeback mux ignores it for non-load instructions.
- Link register (valid bit + address bits [31:2]):
  - LL dhit sets valid and stores alu_out_i[31:2].
  - These events clear valid:
    - SC success;
    - any SW/SC dhit to the linked address;
    - ccinv_i with ccsnoopaddr_i[31:2] == link address.
  - Simultaneous LL dhit and matching snoop: the set wins.
  - Snoop clears the link during an SC in ACCESS before dhit: abort. Drop dWEN_o the next cycle, go to HOLD with dload = 0. The write is never issued.

## Timing
- Reset values: state IDLE, link valid 0, link address 0, dload_o 0. All request outputs 0, halted_o 0.
- RST asserted mid-ACCESS or mid-FLUSH: requests drop after that edge. No partial result is kept.
- Request outputs are Moore outputs: a request starts one cycle after the op enters the stage.
- Minimum latency with a cache hit in the first ACCESS cycle:
  - cycle 0: IDLE, stall;
  - cycle 1: ACCESS, dhit;
  - cycle 2: HOLD, no stall, advance.
  - Total: 2 stall cycles.
- Cache miss: ACCESS persists for as many cycles as dhit_i stays low. daddr_o and dstore_o stay stable throughout, because EX/MEM is frozen.
- SC failure: stall for one cycle (IDLE), then HOLD.
- dhit_i outside ACCESS is ignored.

## Structure
- `cpu_types_pkg` gains:
  - `mem_state_t` enum {IDLE, ACCESS, HOLD, FLUSH, HALTED};
  - localparams MEM_READ = 2'b01 and MEM_WRITE = 2'b10.
- `word_t`, `opcode_t` and the LW/SW/LL/SC opcodes already live in `cpu_types_pkg`.
- One sub-module, `link_reg`: holds the valid bit and address, and implements the set/clear/priority rules above. It exposes `link_hit` for the SC decision.

## Test plan
- LW at 0x100, dhit in the first ACCESS cycle with data 0xDEADBEEF:
  - dREN_o high for exactly 1 cycle; mem_stall_o high for 2 cycles;
  - dload_o = 0xDEADBEEF in HOLD.
- SW of 0x12345678 to 0x200 with dhit delayed 5 cycles: dWEN_o high for 6 cycles with daddr_o and dstore_o stable; HOLD; back to IDLE on advance_i.
- LL 0x300, then SC 0x300:
  - SC writes, dload_o = 1, link cleared.
  - A second SC to 0x300 issues no dWEN_o and returns 0.
- LL 0x300; ccinv_i with snoop address 0x304 keeps the link; snoop address 0x300 clears it. The following SC returns 0 with no write.
- SC to the linked address in ACCESS, snoop hit to that address before dhit: dWEN_o drops the next cycle and dload_o = 0.
- halt_i: dflush_o held until dflushed_i arrives 10 cycles later. Then halted_o = 1 and stall remains high until RST; RST returns all outputs to their reset values.
